seq_add_x8: RTL and testbench
=============================

SEQ_ADD_X8 -- requirements
Module: seq_add_x8

Interface
REQ-001 Parameter WORDS, default 4, meaning number of 8-bit chunks; operand width N = 8*WORDS; legal range 2..8.
REQ-002 clk  input  1  rising-edge clock, the only clock.
REQ-003 rst_n  input  1  asynchronous active-low reset.
REQ-004 start  input  1  request to begin an operation; sampled only when busy=0.
REQ-005 sub  input  1  operation select: 0 computes a+b, 1 computes a-b; captured with start.
REQ-006 a  input  N  first operand; captured with start.
REQ-007 b  input  N  second operand; captured with start.
REQ-008 busy  output  1  operation in progress.
REQ-009 done  output  1  one-cycle pulse; s, c_out and ovf are valid in that cycle.
REQ-010 s  output  N  result.
REQ-011 c_out  output  1  carry out of bit N-1; for sub, 1 means no borrow.
REQ-012 ovf  output  1  two's-complement overflow flag.

Function
REQ-013 The block shall instantiate exactly one clax8 and reuse it serially, one chunk per cycle, starting at the LSB chunk.
REQ-014 The FSM shall have three states: IDLE, RUN and DONE.
  - IDLE to RUN: on start.
  - RUN to DONE: after the cycle that processes chunk WORDS-1.
  - DONE to RUN: on start.
  - DONE to IDLE: otherwise.
REQ-015 Start shall be accepted in IDLE or DONE, which gives back-to-back operation with no gap cycle; start is ignored in RUN.
REQ-016 On acceptance the block shall register a, b and sub, clear the chunk index to 0, and load carry_reg with sub.
REQ-017 In RUN with chunk index k, the clax8 inputs shall be:
  - a: a_reg[8k+7:8k].
  - b: b_reg[8k+7:8k] XOR {8{sub_reg}}.
  - c_in: carry_reg.
REQ-018 The chunk carry shall be computed as g_out | (p_out & carry_reg); it shall be registered into carry_reg at the end of each RUN cycle.
REQ-019 Chunk k's clax8 sum shall be written into s[8k+7:8k] at the end of RUN cycle k; bits not yet written shall hold their prior value.
REQ-020 Latency shall be WORDS+1 cycles from start sampled high to the done pulse; busy shall be high in exactly the WORDS RUN cycles.
REQ-021 done shall be high only in DONE.
REQ-022 s, c_out and ovf shall hold their values after DONE until the next accepted start begins overwriting them.
REQ-023 c_out shall equal carry_reg in DONE.
REQ-024 The chunk index shall count 0..WORDS-1 and shall never wrap inside one operation.
REQ-025 Result arithmetic shall be modulo 2^N.

Reset
REQ-026 rst_n low shall, asynchronously:
  - force the state to IDLE;
  - force busy=0, done=0, s=0, c_out=0 and ovf=0;
  - clear the chunk index and carry_reg.
REQ-027 Reset during RUN shall abandon the operation; no done pulse shall follow.
REQ-028 The first start shall be honoured on the first rising edge after rst_n deasserts.

Configuration
REQ-029 Macro SEQ_ADD_OVF_EN: when defined, ovf shall be registered at the end of the chunk WORDS-1 cycle as (a_msb == b'_msb) & (s_msb != a_msb), where b' is the inverted b when sub=1.
REQ-030 Without SEQ_ADD_OVF_EN, ovf shall be tied to 0 and no overflow logic shall be synthesised; all other behaviour shall be unchanged.

Verification
REQ-031 WORDS=4, a=0xFFFFFFFF, b=0x00000001, sub=0 -> done at cycle 5: s=0x00000000, c_out=1, ovf=0.
REQ-032 WORDS=4, a=0x7FFFFFFF, b=0x00000001, sub=0 -> s=0x80000000, c_out=0, ovf=1 with the macro, ovf=0 without it.
REQ-033 WORDS=4, a=5, b=7, sub=1 -> s=0xFFFFFFFE, c_out=0, ovf=0; a=7, b=5, sub=1 -> s=0x00000002, c_out=1.
REQ-034 Start pulsed with new operands in RUN cycle 2 -> ignored; the result equals the first operation's, and a single done pulse occurs.
REQ-035 rst_n low in RUN cycle 2 -> all outputs 0 immediately and no done pulse; start after release -> correct result at latency 5.
REQ-036 Start held high through DONE with a=0x12345678, b=0x11111111 -> the second operation enters RUN with no idle cycle; the next done shows s=0x23456789.

Source files
------------

// File: rtl/seq_add_x8.sv
// -----------------------------------------------------------------------------
// seq_add_x8 -- serial N-bit adder/subtractor built from one 8-bit
// carry-lookahead slice (clax8) that is reused once per cycle, LSB chunk first.
//
// Parameter
//   WORDS      number of 8-bit chunks, N = 8*WORDS, legal range 2..8
//
// Ports
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   start      begin an operation; sampled only when busy=0 (IDLE or DONE)
//   sub        0: a+b, 1: a-b; captured with start
//   a, b       N-bit operands; captured with start
//   busy       high in each of the WORDS RUN cycles
//   done       one-cycle pulse; s, c_out and ovf are valid in that cycle
//   s          N-bit result, modulo 2^N
//   c_out      carry out of bit N-1 (for sub, 1 means no borrow)
//   ovf        two's-complement overflow (0 unless SEQ_ADD_OVF_EN)
//   dbg_state  current FSM state (IDLE=0, RUN=1, DONE=2)
//
// Handshake: start is a level request. It is accepted on any rising edge where
// the block is in IDLE or DONE and start=1; while busy=1 start is ignored.
// Each accepted start produces exactly one done pulse WORDS+1 cycles after the
// cycle in which start was sampled, unless reset intervenes.
//
// Configuration macro: SEQ_ADD_OVF_EN -- when defined, the overflow flag is
// computed on the last chunk; when undefined ovf is tied to 0.
// -----------------------------------------------------------------------------

// 8-bit carry-lookahead slice. Every internal carry is a flat sum of
// products over generate/propagate terms, so no carry ripples bit to bit.
//   a, b    8-bit operands
//   c_in    carry into bit 0
//   s       8-bit sum
//   g_out   group generate (carry out of bit 7 independent of c_in)
//   p_out   group propagate (c_in passes straight through all 8 bits)
module clax8 (
  input  logic [7:0] a,
  input  logic [7:0] b,
  input  logic       c_in,
  output logic [7:0] s,
  output logic       g_out,
  output logic       p_out
);

  logic [7:0] g;
  logic [7:0] p;
  logic [7:0] c;

  always_comb begin
    logic acc;
    logic prod;
    g     = a & b;
    p     = a ^ b;
    c     = '0;
    c[0]  = c_in;
    g_out = 1'b0;
    // c[i+1] = g[i] | p[i]g[i-1] | ... | p[i..0]c_in
    for (int i = 0; i < 7; i++) begin
      acc  = 1'b0;
      prod = 1'b1;
      for (int j = i; j >= 0; j--) begin
        acc  = acc | (g[j] & prod);
        prod = prod & p[j];
      end
      c[i+1] = acc | (prod & c_in);
    end
    // Group generate uses the same expansion across all 8 bits, without c_in.
    acc  = 1'b0;
    prod = 1'b1;
    for (int j = 7; j >= 0; j--) begin
      acc  = acc | (g[j] & prod);
      prod = prod & p[j];
    end
    g_out = acc;
    p_out = &p;
    s     = p ^ c;
  end

endmodule

module seq_add_x8 #(
  parameter int WORDS = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               sub,
  input  logic [8*WORDS-1:0] a,
  input  logic [8*WORDS-1:0] b,
  output logic               busy,
  output logic               done,
  output logic [8*WORDS-1:0] s,
  output logic               c_out,
  output logic               ovf,
  output logic [1:0]         dbg_state
);

  localparam int         N    = 8 * WORDS;
  localparam logic [3:0] LAST = 4'(WORDS - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t       state;
  logic [N-1:0] a_reg;
  logic [N-1:0] b_reg;
  logic         sub_reg;
  logic         carry_reg;
  logic [3:0]   idx;

  logic [7:0]   chunk_a;
  logic [7:0]   chunk_b;
  logic [7:0]   chunk_sum;
  logic         chunk_g;
  logic         chunk_p;
  logic         chunk_carry;

  // Subtraction is a + ~b + 1: b is inverted per chunk and the +1 enters
  // as the initial carry (carry_reg is loaded with sub on acceptance).
  assign chunk_a     = a_reg[8*idx +: 8];
  assign chunk_b     = b_reg[8*idx +: 8] ^ {8{sub_reg}};
  assign chunk_carry = chunk_g | (chunk_p & carry_reg);

  clax8 u_clax8 (
    .a     (chunk_a),
    .b     (chunk_b),
    .c_in  (carry_reg),
    .s     (chunk_sum),
    .g_out (chunk_g),
    .p_out (chunk_p)
  );

  assign dbg_state = state;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      s         <= '0;
      c_out     <= 1'b0;
      a_reg     <= '0;
      b_reg     <= '0;
      sub_reg   <= 1'b0;
      carry_reg <= 1'b0;
      idx       <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        // IDLE and DONE behave identically for acceptance, which is what
        // lets a start held through DONE go straight back into RUN.
        IDLE, DONE: begin
          if (start) begin
            state     <= RUN;
            busy      <= 1'b1;
            a_reg     <= a;
            b_reg     <= b;
            sub_reg   <= sub;
            carry_reg <= sub;
            idx       <= '0;
          end else begin
            state <= IDLE;
          end
        end
        RUN: begin
          // Only the current chunk of s is written; the rest holds.
          s[8*idx +: 8] <= chunk_sum;
          carry_reg     <= chunk_carry;
          if (idx == LAST) begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
            c_out <= chunk_carry;
          end else begin
            idx <= idx + 4'd1;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

`ifdef SEQ_ADD_OVF_EN
  // Overflow: operands (after the sub inversion) share a sign and the
  // result sign differs from it. Evaluated on the last chunk only.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf <= 1'b0;
    end else if (state == RUN && idx == LAST) begin
      ovf <= (a_reg[N-1] == (b_reg[N-1] ^ sub_reg)) &&
             (chunk_sum[7] != a_reg[N-1]);
    end
  end
`else
  assign ovf = 1'b0;
`endif

endmodule

// File: tb/tb_seq_add_x8.sv
// -----------------------------------------------------------------------------
// tb_seq_add_x8 -- self-checking bench for seq_add_x8 (WORDS=4, N=32).
// Reference results come from plain integer arithmetic on the operands
// (unsigned compare for carry/borrow, signed range check for overflow).
// Inputs are driven and outputs sampled on the falling clock edge.
// -----------------------------------------------------------------------------
module tb_seq_add_x8;

  localparam int WORDS = 4;
  localparam int N     = 8 * WORDS;
  localparam int W     = N + 2;   // {c_out, ovf, s}

  // ---------------- clock / reset ----------------
  logic         clk   = 1'b0;
  logic         rst_n = 1'b1;
  logic         start = 1'b0;
  logic         sub   = 1'b0;
  logic [N-1:0] a     = '0;
  logic [N-1:0] b     = '0;
  logic         busy;
  logic         done;
  logic [N-1:0] s;
  logic         c_out;
  logic         ovf;
  logic [1:0]   dbg_state;

  always #5 clk = ~clk;

  seq_add_x8 #(.WORDS(WORDS)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .sub       (sub),
    .a         (a),
    .b         (b),
    .busy      (busy),
    .done      (done),
    .s         (s),
    .c_out     (c_out),
    .ovf       (ovf),
    .dbg_state (dbg_state)
  );

  // ---------------- scoreboard ----------------
  int           vectors     = 0;
  int           miscompares = 0;
  logic [W-1:0] exp_q[$];
  logic [W-1:0] last_exp = '0;

  function automatic logic [W-1:0] model(input logic [N-1:0] x,
                                         input logic [N-1:0] y,
                                         input logic op);
    longint       ux;
    longint       uy;
    longint       sx;
    longint       sy;
    longint       sr;
    logic [N-1:0] r;
    logic         c;
    logic         v;
    ux = longint'({32'b0, x});
    uy = longint'({32'b0, y});
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    if (!op) begin
      r  = N'(ux + uy);
      c  = (ux + uy) >= (longint'(1) << N);
      sr = sx + sy;
    end else begin
      r  = N'(ux - uy);
      c  = ux >= uy;
      sr = sx - sy;
    end
`ifdef SEQ_ADD_OVF_EN
    v = (sr > ((longint'(1) << (N - 1)) - 1)) || (sr < -(longint'(1) << (N - 1)));
`else
    v = 1'b0;
    if (sr == 0) v = 1'b0;
`endif
    return {c, v, r};
  endfunction

  task automatic chk(input string tag, input logic [N-1:0] obs, input logic [N-1:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_result();
    logic [W-1:0] e;
    if (exp_q.size() == 0) begin
      chk("exp_q_nonempty", 32'(exp_q.size()), 32'd1);
    end else begin
      e        = exp_q.pop_front();
      last_exp = e;
      chk("s",     s,     e[N-1:0]);
      chk("c_out", 32'(c_out), 32'(e[N+1]));
      chk("ovf",   32'(ovf),   32'(e[N]));
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic launch(input logic [N-1:0] x, input logic [N-1:0] y, input logic op);
    start = 1'b1;
    a     = x;
    b     = y;
    sub   = op;
    exp_q.push_back(model(x, y, op));
  endtask

  // Called at the falling edge where start is driven. inj>0 pulses start with
  // fresh operands in that RUN cycle; hold keeps start high throughout.
  task automatic wait_done(input int inj, input bit hold);
    int cnt;
    bit seen;
    seen = 1'b0;
    for (cnt = 1; cnt <= WORDS + 3; cnt++) begin
      @(negedge clk);
      if (!hold) start = 1'b0;
      if (done) begin
        seen = 1'b1;
        break;
      end
      chk("busy_run", 32'(busy), 32'd1);
      if (cnt == inj) begin
        start = 1'b1;
        a     = $urandom;
        b     = $urandom;
        sub   = 1'($urandom_range(0, 1));
      end
    end
    chk("latency", seen ? 32'(cnt) : 32'd0, 32'(WORDS + 1));
    if (seen) begin
      chk("busy_done", 32'(busy), 32'd0);
      check_result();
    end
  endtask

  function automatic logic [N-1:0] pick();
    case ($urandom_range(0, 5))
      0:       return 32'h0000_0000;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h8000_0000;
      3:       return 32'h7FFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  // ---------------- stimulus ----------------
  initial begin
    #2 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_busy",  32'(busy),  32'd0);
    chk("rst_done",  32'(done),  32'd0);
    chk("rst_s",     s,          32'd0);
    chk("rst_c_out", 32'(c_out), 32'd0);
    chk("rst_ovf",   32'(ovf),   32'd0);

    // First start on the first edge after release; carry wraps to zero.
    rst_n = 1'b1;
    launch(32'hFFFF_FFFF, 32'h0000_0001, 1'b0);
    wait_done(0, 1'b0);

    // Results hold in IDLE, done is a single pulse.
    repeat (2) begin
      @(negedge clk);
      chk("done_pulse", 32'(done), 32'd0);
      chk("s_hold",     s,         last_exp[N-1:0]);
      chk("c_out_hold", 32'(c_out), 32'(last_exp[N+1]));
    end

    launch(32'h7FFF_FFFF, 32'h0000_0001, 1'b0);
    wait_done(0, 1'b0);
    chk("s_0x80000000", s, 32'h8000_0000);
    launch(32'd5, 32'd7, 1'b1);
    wait_done(0, 1'b0);
    chk("s_0xFFFFFFFE", s, 32'hFFFF_FFFE);
    launch(32'd7, 32'd5, 1'b1);
    wait_done(0, 1'b0);

    // Start pulsed mid-RUN with new operands is ignored.
    @(negedge clk);
    launch(32'h0102_0304, 32'h1111_2222, 1'b0);
    wait_done(2, 1'b0);
    repeat (WORDS + 2) begin
      @(negedge clk);
      chk("no_extra_done", 32'(done), 32'd0);
    end

    // Reset in RUN cycle 2 abandons the operation.
    launch(32'hDEAD_BEEF, 32'h0BAD_F00D, 1'b0);
    repeat (2) @(negedge clk);
    start = 1'b0;
    #1 rst_n = 1'b0;
    #1;
    chk("arst_busy",  32'(busy),  32'd0);
    chk("arst_done",  32'(done),  32'd0);
    chk("arst_s",     s,          32'd0);
    chk("arst_c_out", 32'(c_out), 32'd0);
    chk("arst_ovf",   32'(ovf),   32'd0);
    void'(exp_q.pop_back());
    repeat (2) begin
      @(negedge clk);
      chk("rst_no_done", 32'(done), 32'd0);
    end
    rst_n = 1'b1;
    launch(32'h1234_0000, 32'h0000_5678, 1'b1);
    wait_done(0, 1'b0);

    // Start held through DONE: second op enters RUN with no idle cycle.
    launch(32'd3, 32'd4, 1'b0);
    wait_done(0, 1'b1);
    launch(32'h1234_5678, 32'h1111_1111, 1'b0);
    wait_done(0, 1'b0);
    chk("s_0x23456789", s, 32'h2345_6789);

    // Random operations, some back-to-back, some with idle gaps.
    for (int i = 0; i < 30; i++) begin
      repeat ($urandom_range(0, 2)) @(negedge clk);
      launch(pick(), pick(), 1'($urandom_range(0, 1)));
      wait_done(0, 1'b0);
    end

    chk("exp_q_drained", 32'(exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
